// File: rtl/hicore_lsu_icb_master.sv
// ICB initiator for the load/store unit: combinational cmd issue, in-order
// context FIFO, and read-data alignment / extension on the writeback side.
module hicore_lsu_icb_master #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int OUTS_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            lsu_req_valid,
  output logic            lsu_req_ready,
  input  logic            lsu_req_load,
  input  logic [AW-1:0]   lsu_req_addr,
  input  logic [DW-1:0]   lsu_req_wdata,
  input  logic [1:0]      lsu_req_size,
  input  logic            lsu_req_usign,
  input  logic [4:0]      lsu_req_rd,

  output logic            lsu_wb_valid,
  input  logic            lsu_wb_ready,
  output logic [DW-1:0]   lsu_wb_rdata,
  output logic [4:0]      lsu_wb_rd,
  output logic            lsu_wb_err,
  output logic            lsu_wb_misalign,

  output logic            lsu_busy,

  output logic            mem_icb_cmd_valid,
  input  logic            mem_icb_cmd_ready,
  output logic            mem_icb_cmd_read,
  output logic [AW-1:0]   mem_icb_cmd_addr,
  output logic [DW-1:0]   mem_icb_cmd_wdata,
  output logic [DW/8-1:0] mem_icb_cmd_wmask,

  input  logic            mem_icb_rsp_valid,
  output logic            mem_icb_rsp_ready,
  input  logic            mem_icb_rsp_err,
  input  logic [DW-1:0]   mem_icb_rsp_rdata
);

  localparam int PTR_W = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
  localparam int CNT_W = $clog2(OUTS_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(OUTS_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(OUTS_DEPTH - 1);

  typedef struct packed {
    logic       load;
    logic [1:0] size;
    logic       usign;
    logic [4:0] rd;
    logic [1:0] off;
    logic       is_local;
  } ctx_t;

  ctx_t             ctx_mem [OUTS_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;

  logic    fifo_full;
  logic    fifo_empty;
  logic    req_misalign;
  logic    push;
  logic    pop;
  ctx_t    head;
  ctx_t    new_ctx;
  logic [DW-1:0] shifted;
  logic [DW-1:0] load_data;

  assign fifo_full  = (cnt == DEPTH_C);
  assign fifo_empty = (cnt == '0);

  always_comb begin
    unique case (lsu_req_size)
      2'b00:   req_misalign = 1'b0;
      2'b01:   req_misalign = lsu_req_addr[0];
      2'b10:   req_misalign = |lsu_req_addr[1:0];
      default: req_misalign = 1'b1;
    endcase
  end

  // Misaligned requests wait for an empty FIFO so local errors stay ordered.
  assign mem_icb_cmd_valid = lsu_req_valid & ~req_misalign & ~fifo_full;
  assign lsu_req_ready     = req_misalign ? fifo_empty : (~fifo_full & mem_icb_cmd_ready);
  assign mem_icb_cmd_read  = lsu_req_load;
  assign mem_icb_cmd_addr  = lsu_req_addr;

  always_comb begin
    mem_icb_cmd_wmask = '0;
    if (!lsu_req_load) begin
      unique case (lsu_req_size)
        2'b00:   mem_icb_cmd_wmask = 4'b0001 << lsu_req_addr[1:0];
        2'b01:   mem_icb_cmd_wmask = 4'b0011 << {lsu_req_addr[1], 1'b0};
        default: mem_icb_cmd_wmask = 4'b1111;
      endcase
    end
  end

  always_comb begin
    unique case (lsu_req_size)
      2'b00:   mem_icb_cmd_wdata = {4{lsu_req_wdata[7:0]}};
      2'b01:   mem_icb_cmd_wdata = {2{lsu_req_wdata[15:0]}};
      default: mem_icb_cmd_wdata = lsu_req_wdata;
    endcase
  end

  assign push = lsu_req_valid & lsu_req_ready;
  assign pop  = lsu_wb_valid & lsu_wb_ready;

  assign new_ctx = '{
    load:     lsu_req_load,
    size:     lsu_req_size,
    usign:    lsu_req_usign,
    rd:       lsu_req_rd,
    off:      lsu_req_addr[1:0],
    is_local: req_misalign
  };

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Context storage carries no reset; entries are only read while counted.
  always_ff @(posedge clk) begin
    if (push) begin
      ctx_mem[wr_ptr] <= new_ctx;
    end
  end

  assign head = ctx_mem[rd_ptr];

  assign lsu_wb_valid      = ~fifo_empty & (head.is_local | mem_icb_rsp_valid);
  assign mem_icb_rsp_ready = ~fifo_empty & ~head.is_local & lsu_wb_ready;
  assign lsu_wb_rd         = head.rd;
  assign lsu_wb_err        = ~fifo_empty & ~head.is_local & mem_icb_rsp_err;
  assign lsu_wb_misalign   = ~fifo_empty & head.is_local;
  assign lsu_busy          = ~fifo_empty;

  assign shifted = mem_icb_rsp_rdata >> {head.off, 3'b000};

  always_comb begin
    unique case (head.size)
      2'b00:   load_data = head.usign ? {24'b0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = head.usign ? {16'b0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  assign lsu_wb_rdata = (head.is_local | ~head.load) ? '0 : load_data;

endmodule
